axis_async_fifo: RTL
====================

AXIS_ASYNC_FIFO -- requirements
Module: axis_async_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 64, payload width in bits (>=1).
REQ-002 Parameter ADDR_WIDTH, default 4, log2 of storage depth (DEPTH = 2**ADDR_WIDTH, ADDR_WIDTH>=2).
REQ-003 Parameter SYNC_STAGES, default 2, flip-flops per pointer synchronizer (>=2).
REQ-004 reset  input  1  asynchronous, active-high, common to both domains.
REQ-005 s_axis_aclk  input  1  write-side clock.
REQ-006 m_axis_aclk  input  1  read-side clock, unrelated to s_axis_aclk.
REQ-007 s_axis_tvalid  input  1  write word valid.
REQ-008 s_axis_tready  output  1  FIFO can accept a word.
REQ-009 s_axis_tdata  input  DATA_WIDTH  write payload.
REQ-010 s_axis_tlast  input  1  end-of-packet marker, stored with the payload.
REQ-011 m_axis_tvalid  output  1  read word valid.
REQ-012 m_axis_tready  input  1  consumer accepts the word.
REQ-013 m_axis_tdata  output  DATA_WIDTH  read payload.
REQ-014 m_axis_tlast  output  1  end-of-packet marker of the presented word.
REQ-015 s_fill  output  ADDR_WIDTH+1  occupancy seen from s domain (conservative: may over-report).
REQ-016 m_fill  output  ADDR_WIDTH+1  occupancy seen from m domain (conservative: may under-report).

Function
REQ-017 Write occurs on an s_axis_aclk edge when s_axis_tvalid && s_axis_tready; {tlast,tdata} are stored at wr_ptr and wr_ptr increments.
REQ-018 Read occurs on an m_axis_aclk edge when m_axis_tvalid && m_axis_tready; rd_ptr increments.
REQ-019 Pointers are ADDR_WIDTH+1 bits binary, wrapping modulo 2**(ADDR_WIDTH+1); only their Gray-coded registered forms cross domains.
REQ-020 Full (s domain) when wr_gray equals synchronized rd_gray with its two MSBs inverted; s_axis_tready = !full && !reset.
REQ-021 Empty (m domain) when rd_gray equals synchronized wr_gray; m_axis_tvalid = !empty.
REQ-022 Exactly DEPTH words are storable; the DEPTH+1th write stalls until a read has propagated back.
REQ-023 Output is first-word-fall-through: m_axis_tdata/tlast show the word at rd_ptr whenever m_axis_tvalid=1.
REQ-024 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tlast/tvalid hold stable.
REQ-025 Latency: first write into an empty FIFO raises m_axis_tvalid within SYNC_STAGES+2 m_axis_aclk edges.
REQ-026 A read from a full FIFO raises s_axis_tready within SYNC_STAGES+2 s_axis_aclk edges.
REQ-027 Sustained throughput is one word per cycle of the slower clock, with no bubbles when not full/empty.
REQ-028 Simultaneous write and read in one domain's view never corrupt data; pointer wrap-around is seamless.
REQ-029 s_fill = wr_ptr - gray2bin(synced rd_gray); m_fill = gray2bin(synced wr_gray) - rd_ptr, modulo 2**(ADDR_WIDTH+1).
REQ-030 Writes while full and reads while empty are ignored (no pointer change).

Reset
REQ-031 Reset asynchronously clears pointers, Gray registers, synchronizers and fill outputs to 0 in both domains; memory contents are not reset.
REQ-032 During reset s_axis_tready=0 and m_axis_tvalid=0; first s edge after release gives s_axis_tready=1.
REQ-033 Reset mid-operation discards all stored words; no stale word is ever presented afterward.
REQ-034 Reset shall be held for at least SYNC_STAGES+1 cycles of the slower clock.

Structure
REQ-035 Package axis_cdc_pkg holds bin2gray and gray2bin functions parametrised by width.
REQ-036 Pointer crossing reuses the existing synchronizer module (RESET_VALUE 0, NUM_FLIP_FLOPS=SYNC_STAGES), one instance per Gray bit.
REQ-037 Storage is a simple dual-port array of DEPTH x (DATA_WIDTH+1), written in s domain, read asynchronously by address in m domain.

Verification
REQ-038 s=100 MHz, m=33 MHz, DEPTH=16: write 0..99 back-to-back, m_axis_tready=1 -> read 0..99 in order, none lost.
REQ-039 m_axis_tready=0, write 17 words -> 16 accepted, s_axis_tready=0 after 16th, s_fill=16.
REQ-040 From full, one read -> s_axis_tready returns within SYNC_STAGES+2 s edges; 17th word then accepted.
REQ-041 Empty FIFO, single write 0xA5 with tlast=1 -> m_axis_tvalid within 4 m edges, tdata=0xA5, tlast=1, held under random tready stalls.
REQ-042 Write 10 words, assert reset 3 slow cycles mid-stream -> tvalid=0, fills=0; post-reset word 0x55 read first.
REQ-043 Random tvalid/tready both sides, 10,000 words, ratios 1:3 and 3:1 -> scoreboard match, pointers wrap >100 times.

Source files
------------

// File: rtl/axis_cdc_pkg.sv
// Gray-code helpers shared by the clock-domain-crossing blocks.
// Both functions operate on the low 'width' bits and ignore everything above them.
package axis_cdc_pkg;

   localparam int GRAY_MAX_W = 32;

   typedef logic [GRAY_MAX_W-1:0] gray_word_t;

   function automatic gray_word_t width_mask(input int unsigned width);
      return (width >= GRAY_MAX_W) ? '1 : ((gray_word_t'(1) << width) - gray_word_t'(1));
   endfunction

   function automatic gray_word_t bin2gray(input gray_word_t bin, input int unsigned width);
      gray_word_t b;
      b = bin & width_mask(width);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at and above it.
   function automatic gray_word_t gray2bin(input gray_word_t gray, input int unsigned width);
      gray_word_t g;
      gray_word_t b;
      g = gray & width_mask(width);
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/synchronizer.sv
// Single-bit multi-flop synchronizer with asynchronous, active-high reset.
module synchronizer #(
   parameter int   NUM_FLIP_FLOPS = 2,
   parameter logic RESET_VALUE    = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [NUM_FLIP_FLOPS-1:0] sync_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_reg <= {NUM_FLIP_FLOPS{RESET_VALUE}};
      end else begin
         sync_reg <= {sync_reg[NUM_FLIP_FLOPS-2:0], d};
      end
   end

   assign q = sync_reg[NUM_FLIP_FLOPS-1];

endmodule

// File: rtl/axis_async_fifo.sv
// AXI-Stream asynchronous FIFO, first-word-fall-through, Gray-coded pointer crossing.
// Payload and tlast share one storage word; only registered Gray pointers cross domains.
module axis_async_fifo
   import axis_cdc_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  reset,
   input  logic                  s_axis_aclk,
   input  logic                  m_axis_aclk,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic [ADDR_WIDTH:0]   s_fill,
   output logic [ADDR_WIDTH:0]   m_fill
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int PTR_W = ADDR_WIDTH + 1;

   logic [DATA_WIDTH:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] wr_ptr_next;
   logic [PTR_W-1:0] wr_gray;
   logic [PTR_W-1:0] rd_gray_sync;
   logic [PTR_W-1:0] rd_ptr_sync_bin;
   logic [PTR_W-1:0] full_pattern;
   logic             full;
   logic             wr_en;

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_next;
   logic [PTR_W-1:0] rd_gray;
   logic [PTR_W-1:0] wr_gray_sync;
   logic [PTR_W-1:0] wr_ptr_sync_bin;
   logic             empty;
   logic             rd_en;

   // Write domain
   assign full_pattern  = {~rd_gray_sync[PTR_W-1 -: 2], rd_gray_sync[PTR_W-3:0]};
   assign full          = (wr_gray == full_pattern);
   assign s_axis_tready = !full && !reset;
   assign wr_en         = s_axis_tvalid && s_axis_tready;
   assign wr_ptr_next   = wr_ptr + 1'b1;

   always_ff @(posedge s_axis_aclk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         wr_gray <= '0;
      end else if (wr_en) begin
         wr_ptr  <= wr_ptr_next;
         wr_gray <= PTR_W'(bin2gray(gray_word_t'(wr_ptr_next), PTR_W));
      end
   end

   always_ff @(posedge s_axis_aclk) begin
      if (wr_en) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   // The synchronized read pointer lags, so this can only over-report occupancy.
   assign rd_ptr_sync_bin = PTR_W'(gray2bin(gray_word_t'(rd_gray_sync), PTR_W));
   assign s_fill          = wr_ptr - rd_ptr_sync_bin;

   // Read domain
   assign empty         = (rd_gray == wr_gray_sync);
   assign m_axis_tvalid = !empty;
   assign rd_en         = m_axis_tvalid && m_axis_tready;
   assign rd_ptr_next   = rd_ptr + 1'b1;

   always_ff @(posedge m_axis_aclk or posedge reset) begin
      if (reset) begin
         rd_ptr  <= '0;
         rd_gray <= '0;
      end else if (rd_en) begin
         rd_ptr  <= rd_ptr_next;
         rd_gray <= PTR_W'(bin2gray(gray_word_t'(rd_ptr_next), PTR_W));
      end
   end

   assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr[ADDR_WIDTH-1:0]];

   assign wr_ptr_sync_bin = PTR_W'(gray2bin(gray_word_t'(wr_gray_sync), PTR_W));
   assign m_fill          = wr_ptr_sync_bin - rd_ptr;

   // One synchronizer per Gray bit in each direction
   for (genvar g = 0; g < PTR_W; g++) begin : g_ptr_sync
      synchronizer #(
         .NUM_FLIP_FLOPS (SYNC_STAGES),
         .RESET_VALUE    (1'b0)
      ) u_rd2wr (
         .clk   (s_axis_aclk),
         .reset (reset),
         .d     (rd_gray[g]),
         .q     (rd_gray_sync[g])
      );

      synchronizer #(
         .NUM_FLIP_FLOPS (SYNC_STAGES),
         .RESET_VALUE    (1'b0)
      ) u_wr2rd (
         .clk   (m_axis_aclk),
         .reset (reset),
         .d     (wr_gray[g]),
         .q     (wr_gray_sync[g])
      );
   end

endmodule
